// File: rtl/archlearn_pkg.sv
// Shared types for the convolution address generator:
// FSM encoding, latched layer configuration and delay bound.
package archlearn_pkg;

    localparam int LAT_MAX = 7;
    localparam int CFG_W   = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [CFG_W-1:0] dim_img;
        logic [CFG_W-1:0] dim_out;
        logic [CFG_W-1:0] dim_k;
        logic [CFG_W-1:0] ch_in;
        logic [CFG_W-1:0] ch_out;
        logic [CFG_W-1:0] stride;
        logic [CFG_W-1:0] pad;
    } cfg_t;

endpackage

// File: rtl/conv_loop_cnt.sv
// Six nested wrap/carry counters (oc, oy, ox, ky, kx, ic),
// innermost ic, with pixel-first / pixel-last / run-last flags.
module conv_loop_cnt
    import archlearn_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             adv,
    input  logic [CFG_W-1:0] n_out,
    input  logic [CFG_W-1:0] n_k,
    input  logic [CFG_W-1:0] n_ic,
    input  logic [CFG_W-1:0] n_oc,
    output logic [CFG_W-1:0] oc,
    output logic [CFG_W-1:0] oy,
    output logic [CFG_W-1:0] ox,
    output logic [CFG_W-1:0] ky,
    output logic [CFG_W-1:0] kx,
    output logic [CFG_W-1:0] ic,
    output logic             first,
    output logic             pix_last,
    output logic             last
);

    localparam logic [CFG_W-1:0] ONE = CFG_W'(1);

    logic [CFG_W-1:0] oc_q, oy_q, ox_q, ky_q, kx_q, ic_q;
    logic [CFG_W-1:0] oc_d, oy_d, ox_d, ky_d, kx_d, ic_d;
    logic w_ic, w_kx, w_ky, w_ox, w_oy, w_oc;

    function automatic logic [CFG_W-1:0] step(
        input logic [CFG_W-1:0] v,
        input logic             wrap,
        input logic             en
    );
        if (!en) return v;
        return wrap ? '0 : v + ONE;
    endfunction

    // Wrap detection and carry chain from ic outward to oc
    always_comb begin
        w_ic = (ic_q == n_ic - ONE);
        w_kx = (kx_q == n_k - ONE);
        w_ky = (ky_q == n_k - ONE);
        w_ox = (ox_q == n_out - ONE);
        w_oy = (oy_q == n_out - ONE);
        w_oc = (oc_q == n_oc - ONE);
        ic_d = step(ic_q, w_ic, adv);
        kx_d = step(kx_q, w_kx, adv & w_ic);
        ky_d = step(ky_q, w_ky, adv & w_ic & w_kx);
        ox_d = step(ox_q, w_ox, adv & w_ic & w_kx & w_ky);
        oy_d = step(oy_q, w_oy, adv & w_ic & w_kx & w_ky & w_ox);
        oc_d = step(oc_q, w_oc, adv & w_ic & w_kx & w_ky & w_ox & w_oy);
        if (clr) begin
            ic_d = '0;
            kx_d = '0;
            ky_d = '0;
            ox_d = '0;
            oy_d = '0;
            oc_d = '0;
        end
    end

    // Counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            ic_q <= '0;
            kx_q <= '0;
            ky_q <= '0;
            ox_q <= '0;
            oy_q <= '0;
            oc_q <= '0;
        end else begin
            ic_q <= ic_d;
            kx_q <= kx_d;
            ky_q <= ky_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
            oc_q <= oc_d;
        end
    end

    assign oc       = oc_q;
    assign oy       = oy_q;
    assign ox       = ox_q;
    assign ky       = ky_q;
    assign kx       = kx_q;
    assign ic       = ic_q;
    assign first    = (ic_q == '0) && (kx_q == '0) && (ky_q == '0);
    assign pix_last = w_ic & w_kx & w_ky;
    assign last     = w_ic & w_kx & w_ky & w_ox & w_oy & w_oc;

endmodule

// File: rtl/conv_addr_gen.sv
// Runtime-configured conv sequencer: FSM, address arithmetic
// with padding detection, and the LAT-deep MAC strobe delay line.
module conv_addr_gen
    import archlearn_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    input  logic [DIM_W-1:0]  cfg_dim_img,
    input  logic [DIM_W-1:0]  cfg_dim_out,
    input  logic [DIM_W-1:0]  cfg_dim_k,
    input  logic [DIM_W-1:0]  cfg_ch_in,
    input  logic [DIM_W-1:0]  cfg_ch_out,
    input  logic [DIM_W-1:0]  cfg_stride,
    input  logic [DIM_W-1:0]  cfg_pad,
    output logic [ADDR_W-1:0] s_addr,
    output logic [ADDR_W-1:0] w_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] save_addr,
    output logic              pad_zero,
    output logic              mac_en,
    output logic              mac_first,
    output logic              en_write,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam int LD = (LAT < 1) ? 1 : ((LAT > LAT_MAX) ? LAT_MAX : LAT);
    localparam int CW = CFG_W + 2;

    state_e            state_q, state_d;
    cfg_t              cfg_q, cfg_d;
    logic              err_q, err_d;
    logic [3:0]        drn_q, drn_d;
    logic              accept, bad_in, issue;

    logic [CFG_W-1:0]  oc, oy, ox, ky, kx, ic;
    logic              t_first, t_plast, t_last;

    logic [CW-1:0]     iy, ix;
    logic              pad_c;
    logic [ADDR_W-1:0] s_c, w_c, sv_c;

    logic [ADDR_W-1:0] s_q, s_d, w_q, w_d, b_q, b_d;
    logic [ADDR_W-1:0] save_q, save_d;
    logic              pad_q, pad_d, wr_q, wr_d;
    logic [LD-1:0]     vld_q, vld_d, fst_q, fst_d, lst_q, lst_d;
    logic [ADDR_W-1:0] sv_q [LD];
    logic [ADDR_W-1:0] sv_d [LD];

    function automatic logic [ADDR_W-1:0] mad(
        input logic [ADDR_W-1:0] a,
        input logic [ADDR_W-1:0] b,
        input logic [ADDR_W-1:0] c
    );
        return a * b + c;
    endfunction

    conv_loop_cnt u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (accept),
        .adv      (issue),
        .n_out    (cfg_q.dim_out),
        .n_k      (cfg_q.dim_k),
        .n_ic     (cfg_q.ch_in),
        .n_oc     (cfg_q.ch_out),
        .oc       (oc),
        .oy       (oy),
        .ox       (ox),
        .ky       (ky),
        .kx       (kx),
        .ic       (ic),
        .first    (t_first),
        .pix_last (t_plast),
        .last     (t_last)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: zero-field configs skip straight to DONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = bad_in ? S_DONE : S_RUN;
            S_RUN:   if (issue && t_last) state_d = S_DRAIN;
            S_DRAIN: if (drn_q == 4'(LD)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and handshake decode
    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        issue  = (state_q == S_RUN) && !stall;
        accept = (state_q == S_IDLE) && start;
        bad_in = (cfg_dim_img == '0) || (cfg_dim_out == '0) ||
                 (cfg_dim_k == '0) || (cfg_ch_in == '0) ||
                 (cfg_ch_out == '0) || (cfg_stride == '0);
    end

    // Input coordinates, padding test and tap addresses
    always_comb begin
        iy    = CW'(oy) * CW'(cfg_q.stride) - CW'(cfg_q.pad) + CW'(ky);
        ix    = CW'(ox) * CW'(cfg_q.stride) - CW'(cfg_q.pad) + CW'(kx);
        pad_c = iy[CW-1] || ix[CW-1] ||
                (iy >= CW'(cfg_q.dim_img)) || (ix >= CW'(cfg_q.dim_img));
        s_c   = mad(mad(ADDR_W'(iy), ADDR_W'(cfg_q.dim_img), ADDR_W'(ix)),
                    ADDR_W'(cfg_q.ch_in), ADDR_W'(ic));
        if (pad_c) s_c = '0;
        w_c   = mad(mad(mad(ADDR_W'(oc), ADDR_W'(cfg_q.dim_k), ADDR_W'(ky)),
                        ADDR_W'(cfg_q.dim_k), ADDR_W'(kx)),
                    ADDR_W'(cfg_q.ch_in), ADDR_W'(ic));
        sv_c  = mad(mad(ADDR_W'(oy), ADDR_W'(cfg_q.dim_out), ADDR_W'(ox)),
                    ADDR_W'(cfg_q.ch_out), ADDR_W'(oc));
    end

    // Config latch, error flag, drain count, address hold, delay line
    always_comb begin
        cfg_d = cfg_q;
        err_d = err_q;
        if (accept) begin
            cfg_d.dim_img = CFG_W'(cfg_dim_img);
            cfg_d.dim_out = CFG_W'(cfg_dim_out);
            cfg_d.dim_k   = CFG_W'(cfg_dim_k);
            cfg_d.ch_in   = CFG_W'(cfg_ch_in);
            cfg_d.ch_out  = CFG_W'(cfg_ch_out);
            cfg_d.stride  = CFG_W'(cfg_stride);
            cfg_d.pad     = CFG_W'(cfg_pad);
            err_d         = bad_in;
        end
        drn_d = (state_q == S_DRAIN) ? drn_q + 4'd1 : 4'd0;
        s_d   = issue ? s_c : s_q;
        w_d   = issue ? w_c : w_q;
        b_d   = issue ? ADDR_W'(oc) : b_q;
        pad_d = issue ? pad_c : pad_q;
        vld_d[0] = issue;
        fst_d[0] = issue & t_first;
        lst_d[0] = issue & t_plast;
        sv_d[0]  = sv_c;
        for (int i = 1; i < LD; i++) begin
            vld_d[i] = vld_q[i-1];
            fst_d[i] = fst_q[i-1];
            lst_d[i] = lst_q[i-1];
            sv_d[i]  = sv_q[i-1];
        end
        wr_d   = lst_q[LD-1];
        save_d = lst_q[LD-1] ? sv_q[LD-1] : save_q;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_q  <= '0;
            err_q  <= 1'b0;
            drn_q  <= '0;
            s_q    <= '0;
            w_q    <= '0;
            b_q    <= '0;
            pad_q  <= 1'b0;
            vld_q  <= '0;
            fst_q  <= '0;
            lst_q  <= '0;
            wr_q   <= 1'b0;
            save_q <= '0;
            for (int i = 0; i < LD; i++) sv_q[i] <= '0;
        end else begin
            cfg_q  <= cfg_d;
            err_q  <= err_d;
            drn_q  <= drn_d;
            s_q    <= s_d;
            w_q    <= w_d;
            b_q    <= b_d;
            pad_q  <= pad_d;
            vld_q  <= vld_d;
            fst_q  <= fst_d;
            lst_q  <= lst_d;
            wr_q   <= wr_d;
            save_q <= save_d;
            for (int i = 0; i < LD; i++) sv_q[i] <= sv_d[i];
        end
    end

    assign s_addr    = s_q;
    assign w_addr    = w_q;
    assign b_addr    = b_q;
    assign save_addr = save_q;
    assign pad_zero  = pad_q;
    assign mac_en    = vld_q[LD-1];
    assign mac_first = fst_q[LD-1];
    assign en_write  = wr_q;
    assign cfg_err   = err_q;

endmodule
